// File: rtl/blob_stats.sv
// blob_stats: accumulates per-label area, bounding box and coordinate sums over a
// labeled pixel stream. At frame end it picks the largest blob and divides out its centroid.
module blob_stats #(
    parameter int HRES       = 320,
    parameter int VRES       = 180,
    parameter int NUM_LABELS = 64,
    parameter int MIN_AREA   = 10
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] label_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    output logic        busy_out,
    output logic        result_valid_out,
    output logic        found_out,
    output logic [15:0] best_label_out,
    output logic [16:0] area_out,
    output logic [10:0] x_min_out,
    output logic [10:0] x_max_out,
    output logic [9:0]  y_min_out,
    output logic [9:0]  y_max_out,
    output logic [10:0] x_centroid_out,
    output logic [9:0]  y_centroid_out,
    output logic        overflow_out
);
    localparam int LBL_W = $clog2(NUM_LABELS);
    localparam int IDX_W = (LBL_W > 5) ? LBL_W : 5;
    localparam logic [IDX_W-1:0] LAST_LBL = IDX_W'(NUM_LABELS - 1);
    localparam logic [IDX_W-1:0] LAST_DIV = IDX_W'(31);

    typedef enum logic [2:0] {
        S_CLEAR, S_ACCUM, S_DRAIN, S_SCAN, S_DIV_X, S_DIV_Y, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;

    // Statistics table, one entry per label.
    logic [16:0] area_mem [NUM_LABELS];
    logic [31:0] xs_mem   [NUM_LABELS];
    logic [31:0] ys_mem   [NUM_LABELS];
    logic [10:0] xmin_mem [NUM_LABELS];
    logic [10:0] xmax_mem [NUM_LABELS];
    logic [9:0]  ymin_mem [NUM_LABELS];
    logic [9:0]  ymax_mem [NUM_LABELS];

    logic             accept, in_range, frame_end;
    logic             vld_p0, end_p0, vld_p1;
    logic [LBL_W-1:0] lbl_p0, lbl_p1;
    logic [10:0]      x_p0;
    logic [9:0]       y_p0;
    logic             fwd;
    logic [16:0]      cur_area, area_p1;
    logic [31:0]      cur_xs, cur_ys, xs_p1, ys_p1;
    logic [10:0]      cur_xmin, cur_xmax, xmin_p1, xmax_p1;
    logic [9:0]       cur_ymin, cur_ymax, ymin_p1, ymax_p1;

    logic [LBL_W-1:0] s_lbl, best_lbl;
    logic             cand, best_found;
    logic [16:0]      best_area;
    logic [31:0]      best_xs, best_ys;
    logic [10:0]      best_xmin, best_xmax, cx_res;
    logic [9:0]       best_ymin, best_ymax;
    logic [32:0]      div_rem, div_rem_in;
    logic [31:0]      div_quo, div_quo_in;
    logic [64:0]      div_nxt;
    logic             div_done_y;

    // One restoring-division step: returns {remainder, quotient}.
    function automatic logic [64:0] div_step(input logic [32:0] rem, input logic [31:0] quo,
                                             input logic [16:0] dvs);
        logic [32:0] sh;
        sh = {rem[31:0], quo[31]};
        if (sh >= {16'd0, dvs})
            return {sh - {16'd0, dvs}, quo[30:0], 1'b1};
        return {sh, quo[30:0], 1'b0};
    endfunction

    // The pixel right after the frame end is refused so the frame closes cleanly.
    assign accept    = valid_in && (state == S_ACCUM) && !end_p0;
    assign in_range  = label_in < 16'(NUM_LABELS);
    assign frame_end = (hcount_in == 11'(HRES - 1)) && (vcount_in == 10'(VRES - 1));
    assign busy_out  = rst_n_in && (state != S_ACCUM);

    // Stage 0 control: qualify the pixel, flag frame end, track out-of-range labels.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p0       <= 1'b0;
            end_p0       <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            vld_p0 <= accept && (label_in != 16'd0) && in_range;
            end_p0 <= accept && frame_end;
            if (state == S_CLEAR)
                overflow_out <= 1'b0;
            else if (accept && !in_range)
                overflow_out <= 1'b1;
        end
    end

    // Stage 0 data: capture pixel label and coordinates.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            lbl_p0 <= label_in[LBL_W-1:0];
            x_p0   <= hcount_in;
            y_p0   <= vcount_in;
        end
    end

    // Stage 1 read: the entry still in flight in stage 2 is newer than the table copy.
    always_comb begin
        fwd      = vld_p1 && (lbl_p1 == lbl_p0);
        cur_area = fwd ? area_p1 : area_mem[lbl_p0];
        cur_xs   = fwd ? xs_p1   : xs_mem[lbl_p0];
        cur_ys   = fwd ? ys_p1   : ys_mem[lbl_p0];
        cur_xmin = fwd ? xmin_p1 : xmin_mem[lbl_p0];
        cur_xmax = fwd ? xmax_p1 : xmax_mem[lbl_p0];
        cur_ymin = fwd ? ymin_p1 : ymin_mem[lbl_p0];
        cur_ymax = fwd ? ymax_p1 : ymax_mem[lbl_p0];
    end

    // Stage 1 control: valid follows the data into the write stage.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) vld_p1 <= 1'b0;
        else           vld_p1 <= vld_p0;
    end

    // Stage 1 data: compute the updated entry.
    always_ff @(posedge clk_in) begin
        lbl_p1  <= lbl_p0;
        area_p1 <= cur_area + 17'd1;
        xs_p1   <= cur_xs + {21'd0, x_p0};
        ys_p1   <= cur_ys + {22'd0, y_p0};
        xmin_p1 <= (x_p0 < cur_xmin) ? x_p0 : cur_xmin;
        xmax_p1 <= (x_p0 > cur_xmax) ? x_p0 : cur_xmax;
        ymin_p1 <= (y_p0 < cur_ymin) ? y_p0 : cur_ymin;
        ymax_p1 <= (y_p0 > cur_ymax) ? y_p0 : cur_ymax;
    end

    // Stage 2: table write, either the CLEAR sweep or the pipeline result.
    always_ff @(posedge clk_in) begin
        if (state == S_CLEAR) begin
            area_mem[idx[LBL_W-1:0]] <= 17'd0;
            xs_mem[idx[LBL_W-1:0]]   <= 32'd0;
            ys_mem[idx[LBL_W-1:0]]   <= 32'd0;
            xmin_mem[idx[LBL_W-1:0]] <= 11'h7FF;
            xmax_mem[idx[LBL_W-1:0]] <= 11'd0;
            ymin_mem[idx[LBL_W-1:0]] <= 10'h3FF;
            ymax_mem[idx[LBL_W-1:0]] <= 10'd0;
        end else if (vld_p1) begin
            area_mem[lbl_p1] <= area_p1;
            xs_mem[lbl_p1]   <= xs_p1;
            ys_mem[lbl_p1]   <= ys_p1;
            xmin_mem[lbl_p1] <= xmin_p1;
            xmax_mem[lbl_p1] <= xmax_p1;
            ymin_mem[lbl_p1] <= ymin_p1;
            ymax_mem[lbl_p1] <= ymax_p1;
        end
    end

    // FSM state and shared step counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // FSM next state: every timed phase counts idx up from zero.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx + IDX_W'(1);
        case (state)
            S_CLEAR: if (idx == LAST_LBL) begin state_nxt = S_ACCUM; idx_nxt = '0; end
            S_ACCUM: begin
                idx_nxt = '0;
                if (end_p0) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (idx == IDX_W'(1)) begin state_nxt = S_SCAN; idx_nxt = '0; end
            S_SCAN:  if (idx == LAST_LBL) begin state_nxt = S_DIV_X; idx_nxt = '0; end
            S_DIV_X: if (idx == LAST_DIV) begin state_nxt = S_DIV_Y; idx_nxt = '0; end
            S_DIV_Y: if (idx == LAST_DIV) begin state_nxt = S_DONE; idx_nxt = '0; end
            S_DONE:  begin state_nxt = S_CLEAR; idx_nxt = '0; end
            default: begin state_nxt = S_CLEAR; idx_nxt = '0; end
        endcase
    end

    assign s_lbl = idx[LBL_W-1:0];
    assign cand  = (state == S_SCAN) && (idx != '0) &&
                   (area_mem[s_lbl] >= 17'(MIN_AREA)) && (area_mem[s_lbl] > best_area);

    // Scan: strict '>' keeps the lowest label on ties.
    always_ff @(posedge clk_in) begin
        if (state == S_DRAIN) begin
            best_found <= 1'b0;
            best_lbl   <= '0;
            best_area  <= 17'd0;
        end else if (cand) begin
            best_found <= 1'b1;
            best_lbl   <= s_lbl;
            best_area  <= area_mem[s_lbl];
            best_xs    <= xs_mem[s_lbl];
            best_ys    <= ys_mem[s_lbl];
            best_xmin  <= xmin_mem[s_lbl];
            best_xmax  <= xmax_mem[s_lbl];
            best_ymin  <= ymin_mem[s_lbl];
            best_ymax  <= ymax_mem[s_lbl];
        end
    end

    // Divider input: step 0 of each divide loads the dividend from the selected entry.
    always_comb begin
        div_rem_in = (idx == '0) ? 33'd0 : div_rem;
        div_quo_in = (idx == '0) ? ((state == S_DIV_X) ? best_xs : best_ys) : div_quo;
        div_nxt    = div_step(div_rem_in, div_quo_in, best_area);
    end

    assign div_done_y = (state == S_DIV_Y) && (idx == LAST_DIV);

    // Divider iteration; the x quotient is parked while y is divided.
    always_ff @(posedge clk_in) begin
        if ((state == S_DIV_X) || (state == S_DIV_Y))
            {div_rem, div_quo} <= div_nxt;
        if ((state == S_DIV_X) && (idx == LAST_DIV))
            cx_res <= div_nxt[10:0];
    end

    // Result registers, loaded on entry to DONE and held until the next DONE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            result_valid_out <= 1'b0;
            found_out        <= 1'b0;
            best_label_out   <= 16'd0;
            area_out         <= 17'd0;
            x_min_out        <= 11'd0;
            x_max_out        <= 11'd0;
            y_min_out        <= 10'd0;
            y_max_out        <= 10'd0;
            x_centroid_out   <= 11'd0;
            y_centroid_out   <= 10'd0;
        end else begin
            result_valid_out <= div_done_y;
            if (div_done_y) begin
                found_out      <= best_found;
                best_label_out <= best_found ? 16'(best_lbl) : 16'd0;
                area_out       <= best_found ? best_area : 17'd0;
                x_min_out      <= best_found ? best_xmin : 11'd0;
                x_max_out      <= best_found ? best_xmax : 11'd0;
                y_min_out      <= best_found ? best_ymin : 10'd0;
                y_max_out      <= best_found ? best_ymax : 10'd0;
                x_centroid_out <= best_found ? cx_res : 11'd0;
                y_centroid_out <= best_found ? div_nxt[9:0] : 10'd0;
            end
        end
    end
endmodule

// File: tb/tb_blob_stats.sv
// tb_blob_stats: directed frames with hand-computed blob statistics for blob_stats.
module tb_blob_stats;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [15:0] label_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        valid_in;
    logic        busy_out, result_valid_out, found_out, overflow_out;
    logic [15:0] best_label_out;
    logic [16:0] area_out;
    logic [10:0] x_min_out, x_max_out, x_centroid_out;
    logic [9:0]  y_min_out, y_max_out, y_centroid_out;

    int cyc = 0;
    int fe_cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    blob_stats dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .label_in(label_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .valid_in(valid_in), .busy_out(busy_out),
        .result_valid_out(result_valid_out), .found_out(found_out),
        .best_label_out(best_label_out), .area_out(area_out), .x_min_out(x_min_out),
        .x_max_out(x_max_out), .y_min_out(y_min_out), .y_max_out(y_max_out),
        .x_centroid_out(x_centroid_out), .y_centroid_out(y_centroid_out),
        .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int l, input int x, input int y);
        label_in  = 16'(l);
        hcount_in = 11'(x);
        vcount_in = 10'(y);
        valid_in  = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic blob(input int l, input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                send(l, x, y);
    endtask

    task automatic end_frame();
        send(0, 319, 179);
        fe_cyc = cyc;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (busy_out && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_ready"}, busy_out, 0);
        @(posedge clk_in);
        #1;
    endtask

    task automatic expect_result(input string nm, input logic f, input int l, input int a,
                                 input int x0, input int x1, input int y0, input int y1,
                                 input int cx, input int cy, input logic ov);
        int n = 0;
        @(negedge clk_in);
        while (!result_valid_out && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_strobe"}, result_valid_out, 1);
        chk({nm, "_latency"}, cyc - fe_cyc, 131);
        chk({nm, "_found"}, found_out, f);
        chk({nm, "_label"}, best_label_out, l);
        chk({nm, "_area"}, area_out, a);
        chk({nm, "_xmin"}, x_min_out, x0);
        chk({nm, "_xmax"}, x_max_out, x1);
        chk({nm, "_ymin"}, y_min_out, y0);
        chk({nm, "_ymax"}, y_max_out, y1);
        chk({nm, "_cx"}, x_centroid_out, cx);
        chk({nm, "_cy"}, y_centroid_out, cy);
        chk({nm, "_ovf"}, overflow_out, ov);
        @(negedge clk_in);
        chk({nm, "_pulse"}, result_valid_out, 0);
        chk({nm, "_hold"}, area_out, a);
    endtask

    task automatic single_blob_frame();
        for (int y = 20; y <= 22; y++) begin
            send(0, 9, y);
            for (int x = 10; x <= 13; x++) send(5, x, y);
            send(0, 14, y);
            if (y == 21) idle(3);
        end
        end_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int strobes;
        rst_n_in  = 1'b0;
        valid_in  = 1'b0;
        label_in  = 16'd0;
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", busy_out, 0);
        chk("rst_strobe", result_valid_out, 0);
        chk("rst_found", found_out, 0);
        chk("rst_area", area_out, 0);
        chk("rst_ovf", overflow_out, 0);
        rst_n_in = 1'b1;
        #1;
        chk("rel_busy", busy_out, 1);
        n = 0;
        while (busy_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("clear_len", n, 64);
        @(posedge clk_in);
        #1;

        // Single blob
        single_blob_frame();
        expect_result("single", 1, 5, 12, 10, 13, 20, 22, 11, 21, 0);

        // Two blobs, larger wins
        wait_ready("two");
        blob(3, 0, 4, 0, 3);
        blob(7, 50, 55, 10, 14);
        end_frame();
        expect_result("two", 1, 7, 30, 50, 55, 10, 14, 52, 12, 0);

        // Tie with row-interleaved labels: lower label wins
        wait_ready("tie");
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 11; x++)
                send((x < 6) ? 3 : 7, x, y);
        end_frame();
        expect_result("tie", 1, 3, 30, 0, 5, 0, 4, 2, 2, 0);

        // Below MIN_AREA: nothing found
        wait_ready("small");
        blob(2, 100, 108, 50, 50);
        end_frame();
        expect_result("small", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Long same-label run
        wait_ready("fwd");
        blob(4, 0, 39, 5, 5);
        end_frame();
        expect_result("fwd", 1, 4, 40, 0, 39, 5, 5, 19, 5, 0);

        // Out-of-range labels mixed in
        wait_ready("ovf");
        for (int y = 30; y <= 32; y++) begin
            send(100, 19, y);
            for (int x = 20; x <= 24; x++) send(1, x, y);
            send((y == 31) ? 64 : 100, 25, y);
        end
        end_frame();
        expect_result("ovf", 1, 1, 15, 20, 24, 30, 32, 22, 31, 1);
        wait_ready("ovf_clr");
        chk("ovf_cleared", overflow_out, 0);

        // Reset during SCAN
        single_blob_frame();
        repeat (20) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("abort_found", found_out, 0);
        chk("abort_label", best_label_out, 0);
        chk("abort_area", area_out, 0);
        chk("abort_xmax", x_max_out, 0);
        chk("abort_strobe", result_valid_out, 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        chk("abort_busy", busy_out, 1);
        n = 0;
        strobes = 0;
        while (busy_out && n < 200) begin
            @(negedge clk_in);
            n++;
            if (result_valid_out) strobes++;
        end
        chk("abort_clear_len", n, 64);
        repeat (150) begin
            @(negedge clk_in);
            if (result_valid_out) strobes++;
        end
        chk("abort_no_strobe", strobes, 0);
        @(posedge clk_in);
        #1;
        single_blob_frame();
        expect_result("after", 1, 5, 12, 10, 13, 20, 22, 11, 21, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/blob_stats.md
Name: blob_stats

Overview:
- Sits directly downstream of connected_components and consumes its labeled pixel stream (label, hcount, vcount, valid).
- Accumulates per-label area, bounding box and coordinate sums over one frame.
- At end of frame it selects the largest blob with area ≥ MIN_AREA, computes its integer centroid with a sequential divider, and presents the result with a one-cycle strobe for the tracking/control logic.

Parameters:
- HRES, 320, horizontal resolution; the frame-end pixel is at hcount = HRES-1.
- VRES, 180, vertical resolution; the frame-end pixel is at vcount = VRES-1.
- NUM_LABELS, 64, number of stat-table entries; valid labels are 1..NUM_LABELS-1.
- MIN_AREA, 10, minimum area for a blob to be a selection candidate.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- label_in  input  16  pixel label; 0 = background
- hcount_in  input  11  pixel x
- vcount_in  input  10  pixel y
- valid_in  input  1  pixel qualifier
- busy_out  output  1  high while not in ACCUM; pixels are ignored when high
- result_valid_out  output  1  one-cycle strobe when result fields are valid
- found_out  output  1  a blob was selected this frame
- best_label_out  output  16  selected label
- area_out  output  17  selected area
- x_min_out, x_max_out  output  11  bounding box x
- y_min_out, y_max_out  output  10  bounding box y
- x_centroid_out  output  11  floor(x_sum/area)
- y_centroid_out  output  10  floor(y_sum/area)
- overflow_out  output  1  sticky per frame; a label ≥ NUM_LABELS was seen

Behaviour:
- Reset:
  - rst_n_in low asynchronously clears all outputs to 0.
  - The FSM is forced to CLEAR, with index 0.
  - busy_out reads 1 from reset release until CLEAR finishes.
- Table entry fields: area[16:0], x_sum[31:0], y_sum[31:0], x_min/x_max[10:0], y_min/y_max[9:0].
- Empty entry: area 0, sums 0, x_min = 2047, y_min = 1023, x_max = 0, y_max = 0.
- FSM states: CLEAR → ACCUM → DRAIN → SCAN → DIV_X → DIV_Y → DONE → CLEAR.
- CLEAR: writes one entry empty per cycle, NUM_LABELS cycles; also clears overflow_out; then goes to ACCUM.
- ACCUM, pixel handling:
  - A pixel is accepted when valid_in and state == ACCUM.
  - label 0 is ignored.
  - A label ≥ NUM_LABELS sets overflow_out and is otherwise ignored.
  - Update is a 2-stage read-modify-write pipeline: stage 1 reads the entry, stage 2 writes area+1, sums + coordinate, and min/max.
  - Back-to-back pixels with the same label must forward the stage-2 result; no update may be lost.
- ACCUM, frame end:
  - An accepted pixel at (HRES-1, VRES-1) is the frame end, regardless of its label.
  - On frame end the FSM moves to DRAIN on the next edge.
- DRAIN: 2 cycles, flushes the pipeline.
- SCAN:
  - Visits labels 0..NUM_LABELS-1, one per cycle; label 0 is skipped.
  - Candidate condition: area ≥ MIN_AREA and area strictly > current best, so ties go to the lowest label.
  - Latches best label and its entry.
- DIV_X: 32-cycle restoring divide of x_sum by area, truncated to 11 bits.
- DIV_Y: 32-cycle restoring divide of y_sum by area, truncated to 10 bits.
- No candidate:
  - Both divides still run for fixed timing.
  - Results are forced to 0, and found_out = 0.
- DONE:
  - Result outputs are registered; result_valid_out = 1 for exactly this cycle.
  - Result outputs hold until the next DONE or reset.
- Latency: result_valid_out is high exactly 67+NUM_LABELS cycles after the edge that accepts the frame-end pixel (1 + 2 DRAIN + NUM_LABELS SCAN + 64 DIV).
- Pixels arriving in any non-ACCUM state are dropped silently, including the next frame's start if still busy.
- Reset mid-operation (any state) aborts immediately:
  - No result_valid_out strobe for the aborted frame.
  - The table is rebuilt by CLEAR.

Test Plan:
- Single blob: label 5 filling x 10..13, y 20..22 (12 px) in a full 320x180 frame, rest label 0 → found=1, label 5, area 12, bbox (10,13,20,22), centroid (11,21), strobe at accept+131 cycles (NUM_LABELS = 64).
- Two blobs: label 3 area 20, label 7 area 30 → label 7 selected. Second run with both at area 30 → label 3 selected (tie goes to the lower label).
- Small blob only: label 2 area 9 → found=0, all result fields 0, strobe still issued on time.
- Forwarding: one row of 40 consecutive valid pixels with label 4 at y=5, x 0..39 → area 40, x_sum 780, centroid (19,5).
- Out-of-range label: pixels with label 100 mixed with label 1 (area 15) → overflow_out=1, label 1 stats unaffected; overflow_out reads 0 after the next CLEAR.
- Reset mid-SCAN: assert rst_n_in during SCAN → outputs 0 immediately, no strobe, busy_out high for 64 cycles after release. The next frame, with label 5 as in the first test, yields the correct results.
